// File: rtl/uart_rx_if.sv
// uart_rx_if: byte output channel of the UART receiver.
//   data_out       - received byte, LSB-aligned
//   data_out_valid - data_out and error flags valid, held until accepted
//   data_out_ready - consumer accepts when valid && ready
//   check_error    - parity mismatch for the byte on data_out
//   frame_error    - first stop bit sampled low for the byte on data_out
//   overrun_error  - one-cycle pulse, an unaccepted byte was overwritten
// master: the receiver side; slave: the byte consumer.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       check_error;
  logic       frame_error;
  logic       overrun_error;

  modport master (
    output data_out, data_out_valid, check_error, frame_error, overrun_error,
    input  data_out_ready
  );

  modport slave (
    input  data_out, data_out_valid, check_error, frame_error, overrun_error,
    output data_out_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with mid-bit sampling, parity and stop checking.
// Frames on rx are deserialized using an internal bit-period counter
// (N = system_clk / band_rate clocks per bit) and presented on a
// valid/ready byte channel with per-byte error flags.
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   rx_en  - receiver enable; low aborts any frame in progress
//   rx     - raw asynchronous UART line, idle high
//   out_if - byte output channel (uart_rx_if.master)
module uart_rx #(
  parameter int unsigned system_clk = 50_000_000,
  parameter int unsigned band_rate  = 9600,
  parameter int unsigned data_bits  = 8,
  parameter int unsigned check_mode = 1,
  parameter int unsigned stop_mode  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic        rx,
  uart_rx_if.master   out_if
);

  localparam int unsigned N  = system_clk / band_rate;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(N / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [2:0]    IDX_LAST = 3'(data_bits - 1);

  // Only the first stop bit is ever checked, so stop_mode has no effect
  // on the datapath beyond being a legal value.
  if (stop_mode > 2 || check_mode > 4 || data_bits < 5 || data_bits > 8 || N < 4) begin : g_bad_cfg
    $error("uart_rx: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CHECK,
    S_STOP
  } state_t;

  logic          rx_meta, rx_s, rx_s_d;
  logic          fall;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          chk_err, chk_err_n;
  logic          exp_par;
  logic          load;
  logic          frame_err_int;

  // Two-flop synchronizer plus one history flop for edge detection; all
  // reset to the idle line level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_comb begin
    case (check_mode)
      1:       exp_par = ^shift;
      2:       exp_par = ~^shift;
      4:       exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      chk_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      chk_err <= chk_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt + 1'b1;
    idx_n         = idx;
    shift_n       = shift;
    chk_err_n     = chk_err;
    load          = 1'b0;
    frame_err_int = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (fall) state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            shift_n   = '0;
            chk_err_n = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          idx_n        = idx + 1'b1;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = (check_mode != 0) ? S_CHECK : S_STOP;
          end
        end
      end
      S_CHECK: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          chk_err_n = (rx_s != exp_par);
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n         = '0;
          load          = 1'b1;
          frame_err_int = ~rx_s;
          state_n       = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    // Disable wins over everything above, including a completing frame.
    if (!rx_en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_if.data_out       <= '0;
      out_if.data_out_valid <= 1'b0;
      out_if.check_error    <= 1'b0;
      out_if.frame_error    <= 1'b0;
      out_if.overrun_error  <= 1'b0;
    end else begin
      out_if.overrun_error <= load & out_if.data_out_valid & ~out_if.data_out_ready;
      if (load) begin
        out_if.data_out       <= shift;
        out_if.check_error    <= chk_err;
        out_if.frame_error    <= frame_err_int;
        out_if.data_out_valid <= 1'b1;
      end else if (out_if.data_out_valid && out_if.data_out_ready) begin
        out_if.data_out_valid <= 1'b0;
      end
    end
  end

endmodule
